vx_fetch_multi: RTL and testbench

Instruction fetch unit between the warp scheduler and the icache, successor to the single-outstanding-per-warp fetch stage. Supports up to MAX_PENDING in-flight icache requests per warp via a slotted PC/tmask store, with per-warp credit counting. A per-warp flush discards responses to requests already in flight. Requests leave through a 2-entry registered skid buffer; responses are forwarded to the ibuffer in per-warp order.

---
 rtl/vx_fetch_multi.sv | 173 +++++++++++++++++
 tb/tb_vx_fetch_multi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fetch_multi.sv
// rtl/vx_fetch_multi.sv - multi-outstanding instruction fetch unit between scheduler and icache
module vx_fetch_multi #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int UUID_WIDTH  = 1,
  parameter int MAX_PENDING = 2,
  localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int SLOT_BITS  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1,
  localparam int TAG_WIDTH  = UUID_WIDTH + SLOT_BITS + NW_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_BITS-1:0]     sched_wid,
  input  logic [PC_BITS-1:0]     sched_PC,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  input  logic                   flush_valid,
  input  logic [NW_BITS-1:0]     flush_wid,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [ADDR_WIDTH-1:0]  icache_req_addr,
  output logic [TAG_WIDTH-1:0]   icache_req_tag,
  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [DATA_WIDTH-1:0]  icache_rsp_data,
  input  logic [TAG_WIDTH-1:0]   icache_rsp_tag,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_BITS-1:0]     fetch_wid,
  output logic [PC_BITS-1:0]     fetch_PC,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [DATA_WIDTH-1:0]  fetch_instr,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic [NUM_WARPS-1:0]   warp_idle
);

  localparam int CNT_BITS    = $clog2(MAX_PENDING + 1);
  localparam int STORE_DEPTH = 1 << (NW_BITS + SLOT_BITS);
  localparam int ENT_W       = PC_BITS + NUM_THREADS;
  localparam int REQ_W       = ADDR_WIDTH + TAG_WIDTH;
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(MAX_PENDING - 1);
  localparam logic [CNT_BITS-1:0]  MAX_CNT   = CNT_BITS'(MAX_PENDING);
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);

  // per-warp credit / pointer / discard state
  logic [CNT_BITS-1:0]  count   [NUM_WARPS];
  logic [CNT_BITS-1:0]  count_n [NUM_WARPS];
  logic [CNT_BITS-1:0]  stale   [NUM_WARPS];
  logic [SLOT_BITS-1:0] wr_ptr  [NUM_WARPS];
  logic [SLOT_BITS-1:0] rd_ptr  [NUM_WARPS];

  // PC/tmask of every in-flight request, indexed {wid, slot}
  logic [ENT_W-1:0] store [STORE_DEPTH];

  // two-entry request skid buffer, entry 0 is the head
  logic [REQ_W-1:0] buf_q [2];
  logic [1:0]       buf_cnt;
  logic             buf_full;
  logic             req_pop;
  logic [REQ_W-1:0] req_data;

  logic                  sched_fire;
  logic                  rsp_fire;
  logic                  rsp_stale;
  logic [NW_BITS-1:0]    rsp_wid;
  logic [SLOT_BITS-1:0]  rsp_slot;
  logic [UUID_WIDTH-1:0] rsp_uuid;

  function automatic logic [SLOT_BITS-1:0] slot_inc(input logic [SLOT_BITS-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + SLOT_BITS'(1);
  endfunction

  assign rsp_wid  = icache_rsp_tag[NW_BITS-1:0];
  assign rsp_slot = icache_rsp_tag[NW_BITS +: SLOT_BITS];
  assign rsp_uuid = icache_rsp_tag[TAG_WIDTH-1 -: UUID_WIDTH];

  assign buf_full         = (buf_cnt == 2'd2);
  assign icache_req_valid = (buf_cnt != 2'd0);
  assign {icache_req_addr, icache_req_tag} = buf_q[0];
  assign req_pop          = icache_req_valid && icache_req_ready;
  assign req_data         = {sched_PC[ADDR_WIDTH-1:0], sched_uuid, wr_ptr[sched_wid], sched_wid};

  assign sched_ready = (count[sched_wid] < MAX_CNT) && !buf_full &&
                       !(flush_valid && (flush_wid == sched_wid));
  assign sched_fire  = sched_valid && sched_ready;

  // responses to flushed requests are swallowed without bothering the ibuffer
  assign rsp_stale        = (stale[rsp_wid] != '0);
  assign fetch_valid      = icache_rsp_valid && !rsp_stale;
  assign icache_rsp_ready = rsp_stale ? 1'b1 : fetch_ready;
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;

  assign {fetch_PC, fetch_tmask} = store[{rsp_wid, rsp_slot}];
  assign fetch_wid   = rsp_wid;
  assign fetch_instr = icache_rsp_data;
  assign fetch_uuid  = rsp_uuid;

  // next credit count per warp after this cycle's accept and retire
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      count_n[w] = count[w];
      if (sched_fire && (sched_wid == NW_BITS'(w))) count_n[w] = count_n[w] + CNT_ONE;
      if (rsp_fire && (rsp_wid == NW_BITS'(w)))     count_n[w] = count_n[w] - CNT_ONE;
      warp_idle[w] = (count[w] == '0);
    end
  end

  // per-warp credit, pointer and stale-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        stale[w]  <= '0;
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count[w] <= count_n[w];
        if (sched_fire && (sched_wid == NW_BITS'(w))) wr_ptr[w] <= slot_inc(wr_ptr[w]);
        if (rsp_fire && (rsp_wid == NW_BITS'(w)))     rd_ptr[w] <= slot_inc(rd_ptr[w]);
        if (flush_valid && (flush_wid == NW_BITS'(w)))
          stale[w] <= count_n[w];
        else if (rsp_fire && (rsp_wid == NW_BITS'(w)) && (stale[w] != '0))
          stale[w] <= stale[w] - CNT_ONE;
      end
    end
  end

  // capture PC/tmask of each accepted request into its slot
  always_ff @(posedge clk) begin
    if (sched_fire) store[{sched_wid, wr_ptr[sched_wid]}] <= {sched_PC, sched_tmask};
  end

  // skid buffer: push on accept, pop on icache handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_cnt <= 2'd0;
    end else begin
      case ({sched_fire, req_pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf_q[0] <= req_data;
          else                 buf_q[1] <= req_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_q[0] <= req_data;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= req_data;
          end
        end
        default: ;
      endcase
    end
  end

  // the icache must answer each warp in request order
  always_ff @(posedge clk) begin
    if (!reset && icache_rsp_valid) assert (rsp_slot == rd_ptr[rsp_wid]);
  end

endmodule

// File: tb/tb_vx_fetch_multi.sv
// tb/tb_vx_fetch_multi.sv - scoreboard bench for vx_fetch_multi
module tb_vx_fetch_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_valid, sched_ready;
  logic [1:0]  sched_wid;
  logic [29:0] sched_PC;
  logic [3:0]  sched_tmask;
  logic        sched_uuid;
  logic        flush_valid;
  logic [1:0]  flush_wid;
  logic        icache_req_valid, icache_req_ready;
  logic [29:0] icache_req_addr;
  logic [3:0]  icache_req_tag;
  logic        icache_rsp_valid, icache_rsp_ready;
  logic [31:0] icache_rsp_data;
  logic [3:0]  icache_rsp_tag;
  logic        fetch_valid, fetch_ready;
  logic [1:0]  fetch_wid;
  logic [29:0] fetch_PC;
  logic [3:0]  fetch_tmask;
  logic [31:0] fetch_instr;
  logic        fetch_uuid;
  logic [3:0]  warp_idle;

  logic rsp_en;

  typedef struct packed {
    logic        drop;
    logic [1:0]  wid;
    logic [29:0] pc;
    logic [3:0]  tmask;
    logic        uuid;
  } exp_t;

  exp_t        exp_q[$];
  logic [33:0] ic_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  vx_fetch_multi dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready),
    .sched_wid(sched_wid), .sched_PC(sched_PC), .sched_tmask(sched_tmask), .sched_uuid(sched_uuid),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_wid(fetch_wid), .fetch_PC(fetch_PC), .fetch_tmask(fetch_tmask),
    .fetch_instr(fetch_instr), .fetch_uuid(fetch_uuid),
    .warp_idle(warp_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [29:0] a);
    return {2'b01, a} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic drive_rsp();
    logic [29:0] a;
    logic [3:0]  t;
    if (rsp_en && ic_q.size() != 0) begin
      {a, t} = ic_q[0];
      icache_rsp_valid = 1'b1;
      icache_rsp_tag   = t;
      icache_rsp_data  = instr_of(a);
    end else begin
      icache_rsp_valid = 1'b0;
      icache_rsp_tag   = '0;
      icache_rsp_data  = '0;
    end
  endtask

  task automatic settle();
    drive_rsp();
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    int   idx;
    if (reset) return;
    if (sched_valid && sched_ready) begin
      e = '{drop: 1'b0, wid: sched_wid, pc: sched_PC, tmask: sched_tmask, uuid: sched_uuid};
      exp_q.push_back(e);
      n_acc++;
    end
    if (icache_req_valid && icache_req_ready) ic_q.push_back({icache_req_addr, icache_req_tag});
    if (icache_rsp_valid && icache_rsp_ready) begin
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].wid == icache_rsp_tag[1:0]) idx = i;
      chk("rsp_expected", idx >= 0, 1);
      if (idx >= 0) begin
        e = exp_q[idx];
        if (e.drop) begin
          chk("stale_fetch_valid", fetch_valid, 0);
        end else begin
          chk("fetch_valid", fetch_valid, 1);
          chk("fetch_fields", {fetch_wid, fetch_PC, fetch_tmask, fetch_uuid},
              {e.wid, e.pc, e.tmask, e.uuid});
          chk("fetch_instr", fetch_instr, instr_of(e.pc));
        end
        exp_q.delete(idx);
      end
      void'(ic_q.pop_front());
    end
    if (flush_valid) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].wid == flush_wid) begin
          e = exp_q[i];
          e.drop = 1'b1;
          exp_q[i] = e;
        end
      end
    end
  endtask

  task automatic step();
    drive_rsp();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] w, input logic [29:0] pc, input logic [3:0] tm, input logic u);
    bit ok = 1'b0;
    sched_valid = 1'b1; sched_wid = w; sched_PC = pc; sched_tmask = tm; sched_uuid = u;
    for (int i = 0; i < 100 && !ok; i++) begin
      settle();
      ok = sched_ready;
      step();
    end
    sched_valid = 1'b0;
    chk("issue_accepted", ok, 1);
  endtask

  task automatic wait_icq(input int n);
    for (int i = 0; i < 50 && ic_q.size() < n; i++) step();
    chk("icache_queue_fill", ic_q.size(), n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && ic_q.size() == 0 && !icache_req_valid) break;
      step();
    end
    chk(name, exp_q.size() + ic_q.size(), 0);
  endtask

  initial begin
    int target;
    int cyc;
    reset = 1'b1; sched_valid = 1'b0; sched_wid = '0; sched_PC = '0; sched_tmask = '0;
    sched_uuid = 1'b0; flush_valid = 1'b0; flush_wid = '0; icache_req_ready = 1'b0;
    fetch_ready = 1'b0; rsp_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    settle();
    chk("reset_req_valid", icache_req_valid, 0);
    chk("reset_fetch_valid", fetch_valid, 0);
    chk("reset_sched_ready", sched_ready, 1);
    chk("reset_warp_idle", warp_idle, 4'hF);

    // basic single fetch with one-cycle request latency
    sched_valid = 1'b1; sched_wid = 2'd0; sched_PC = 30'h100; sched_tmask = 4'hF; sched_uuid = 1'b0;
    settle();
    chk("t1_ready", sched_ready, 1);
    chk("t1_req_not_yet", icache_req_valid, 0);
    step();
    sched_valid = 1'b0;
    settle();
    chk("t1_req_valid", icache_req_valid, 1);
    chk("t1_req_addr", icache_req_addr, 30'h100);
    chk("t1_req_tag", icache_req_tag, 4'h0);
    chk("t1_busy", warp_idle[0], 0);
    icache_req_ready = 1'b1;
    step();
    rsp_en = 1'b1; fetch_ready = 1'b1;
    settle();
    chk("t1_fetch_valid", fetch_valid, 1);
    chk("t1_fetch_pc", fetch_PC, 30'h100);
    drain("t1_drain");
    chk("t1_idle", warp_idle, 4'hF);

    // credit limit on warp 1, other warps unaffected
    rsp_en = 1'b0;
    issue(2'd1, 30'h200, 4'h3, 1'b0);
    issue(2'd1, 30'h201, 4'h5, 1'b1);
    sched_valid = 1'b1; sched_wid = 2'd1; sched_PC = 30'h202; sched_tmask = 4'h1; sched_uuid = 1'b0;
    settle();
    chk("t2_stall", sched_ready, 0);
    step();
    settle();
    chk("t2_stall_hold", sched_ready, 0);
    sched_valid = 1'b0;
    issue(2'd0, 30'h300, 4'h8, 1'b0);
    rsp_en = 1'b1;
    issue(2'd1, 30'h202, 4'h1, 1'b0);
    drain("t2_drain");

    // flush of two in-flight fetches: both swallowed even with ibuffer stalled
    rsp_en = 1'b0;
    issue(2'd2, 30'h20, 4'h2, 1'b0);
    issue(2'd2, 30'h21, 4'h2, 1'b1);
    wait_icq(2);
    flush_valid = 1'b1; flush_wid = 2'd2;
    step();
    flush_valid = 1'b0;
    fetch_ready = 1'b0; rsp_en = 1'b1;
    settle();
    chk("t3_stale_rsp_ready", icache_rsp_ready, 1);
    chk("t3_stale_no_fetch", fetch_valid, 0);
    drain("t3_drop_drain");
    fetch_ready = 1'b1;
    issue(2'd2, 30'h40, 4'h6, 1'b0);
    drain("t3_after_drain");
    chk("t3_idle", warp_idle[2], 1);

    // flush in the same cycle as a delivered response
    rsp_en = 1'b0;
    issue(2'd3, 30'h30, 4'h9, 1'b0);
    issue(2'd3, 30'h31, 4'h9, 1'b1);
    wait_icq(2);
    rsp_en = 1'b1; flush_valid = 1'b1; flush_wid = 2'd3;
    settle();
    chk("t4_fire_valid", fetch_valid, 1);
    chk("t4_fire_pc", fetch_PC, 30'h30);
    step();
    flush_valid = 1'b0;
    settle();
    chk("t4_second_dropped", fetch_valid, 0);
    drain("t4_drain");

    // ibuffer backpressure holds the response
    rsp_en = 1'b0;
    issue(2'd1, 30'h50, 4'hA, 1'b1);
    wait_icq(1);
    fetch_ready = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_rsp_ready_low", icache_rsp_ready, 0);
      chk("t5_hold", {fetch_valid, fetch_PC, fetch_tmask, warp_idle[1]}, {1'b1, 30'h50, 4'hA, 1'b0});
      step();
    end
    fetch_ready = 1'b1;
    step();
    settle();
    chk("t5_idle", warp_idle[1], 1);
    drain("t5_drain");

    // random interleaved traffic with occasional flushes
    target = n_acc + 1000;
    cyc = 0;
    while (n_acc < target && cyc < 30000) begin
      sched_valid      = ($urandom_range(0, 3) != 0);
      sched_wid        = 2'($urandom_range(0, 3));
      sched_PC         = 30'($urandom);
      sched_tmask      = 4'($urandom);
      sched_uuid       = 1'($urandom);
      flush_valid      = ($urandom_range(0, 39) == 0);
      flush_wid        = 2'($urandom_range(0, 3));
      icache_req_ready = ($urandom_range(0, 3) != 0);
      fetch_ready      = ($urandom_range(0, 3) != 0);
      rsp_en           = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("rand_progress", n_acc >= target, 1);
    sched_valid = 1'b0; flush_valid = 1'b0;
    icache_req_ready = 1'b1; fetch_ready = 1'b1; rsp_en = 1'b1;
    drain("rand_drain");
    settle();
    chk("rand_idle", warp_idle, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
